// File: rtl/mux_nx1_scan.sv
// Registered N-to-1 multiplexer with manual select or round-robin scan mode.
// All outputs are registered; a dwell counter paces the scan per channel.
module mux_nx1_scan #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int DWELL    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]          slt_line,
   input  logic                      mode,
   input  logic                      en,
   output logic [WIDTH-1:0]          out,
   output logic                      out_valid,
   output logic [SEL_W-1:0]          cur_ch,
   output logic                      ch_wrap
);

   localparam int DW     = $clog2(DWELL) + 1;
   localparam int NSLOTS = 2 ** SEL_W;

   localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
   localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);
   localparam logic [SEL_W:0]   CH_COUNT   = (SEL_W + 1)'(CHANNELS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               vld_q, vld_d;
   logic [SEL_W-1:0]   cur_q, cur_d;
   logic               wrap_q, wrap_d;
   logic [DW-1:0]      dwell_q, dwell_d;

   // Unpack the bus into a table covering every select code; unused codes read zero
   // so indexing by any SEL_W value stays in range.
   logic [WIDTH-1:0] ch_w [NSLOTS];

   for (genvar k = 0; k < NSLOTS; k++) begin : g_slot
      if (k < CHANNELS) begin : g_used
         assign ch_w[k] = in_bus[k*WIDTH +: WIDTH];
      end else begin : g_unused
         assign ch_w[k] = '0;
      end
   end

   logic             sel_ok;
   logic             at_last_ch;
   logic [SEL_W-1:0] next_ch;

   assign sel_ok     = ({1'b0, slt_line} < CH_COUNT);
   assign at_last_ch = (cur_q == CH_LAST);
   assign next_ch    = at_last_ch ? '0 : cur_q + SEL_W'(1);

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cur_d   = cur_q;
      dwell_d = dwell_q;
      vld_d   = 1'b0;
      wrap_d  = 1'b0;

      if (en) begin
         if (!mode) begin
            state_d = MANUAL;
            if (sel_ok) begin
               out_d = ch_w[slt_line];
               cur_d = slt_line;
               vld_d = 1'b1;
            end
         end else begin
            state_d = SCAN;
            vld_d   = 1'b1;
            if (state_q != SCAN) begin
               // Any entry into scan restarts from channel 0 without a wrap pulse.
               cur_d   = '0;
               dwell_d = '0;
               out_d   = ch_w[0];
            end else if (dwell_q == DWELL_LAST) begin
               cur_d   = next_ch;
               dwell_d = '0;
               out_d   = ch_w[next_ch];
               wrap_d  = at_last_ch;
            end else begin
               dwell_d = dwell_q + DW'(1);
               out_d   = ch_w[cur_q];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         vld_q   <= 1'b0;
         cur_q   <= '0;
         wrap_q  <= 1'b0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         cur_q   <= cur_d;
         wrap_q  <= wrap_d;
         dwell_q <= dwell_d;
      end
   end

   assign out       = out_q;
   assign out_valid = vld_q;
   assign cur_ch    = cur_q;
   assign ch_wrap   = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: main 4ch/dwell-3 build plus 3ch and dwell-1 builds.
module tb_mux_nx1_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_bus;
   logic [1:0]  slt_line;
   logic        mode;
   logic        en;

   logic [7:0]  out_a, out_b, out_c;
   logic        vld_a, vld_b, vld_c;
   logic [1:0]  cur_a, cur_b, cur_c;
   logic        wrap_a, wrap_b, wrap_c;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mux_nx1_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(3)) u_main (
      .clk(clk), .rst(rst), .in_bus(in_bus), .slt_line(slt_line), .mode(mode), .en(en),
      .out(out_a), .out_valid(vld_a), .cur_ch(cur_a), .ch_wrap(wrap_a)
   );

   mux_nx1_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(3)) u_ch3 (
      .clk(clk), .rst(rst), .in_bus(in_bus[23:0]), .slt_line(slt_line), .mode(mode), .en(en),
      .out(out_b), .out_valid(vld_b), .cur_ch(cur_b), .ch_wrap(wrap_b)
   );

   mux_nx1_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(1)) u_dw1 (
      .clk(clk), .rst(rst), .in_bus(in_bus), .slt_line(slt_line), .mode(mode), .en(en),
      .out(out_c), .out_valid(vld_c), .cur_ch(cur_c), .ch_wrap(wrap_c)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_main(input string tag, input logic [7:0] o, input logic v,
                           input logic [1:0] c, input logic w);
      chk({tag, ".out"},   32'(out_a),  32'(o));
      chk({tag, ".vld"},   32'(vld_a),  32'(v));
      chk({tag, ".cur"},   32'(cur_a),  32'(c));
      chk({tag, ".wrap"},  32'(wrap_a), 32'(w));
   endtask

   logic [7:0] scan_out  [15] = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33,
                                  8'h33, 8'h44, 8'h44, 8'h44, 8'h11, 8'h11, 8'h11};
   logic [1:0] scan_cur  [15] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                  2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
   logic       scan_wrap [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [7:0] dw1_out   [8]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
   logic       dw1_wrap  [8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      rst      = 1'b1;
      en       = 1'b1;
      mode     = 1'b1;
      slt_line = 2'd0;
      in_bus   = 32'h44332211;

      // Reset held two cycles with en/mode asserted
      step();
      step();
      chk_main("reset", 8'h00, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;
      en  = 1'b0;
      step();
      chk_main("idle_paused", 8'h00, 1'b0, 2'd0, 1'b0);

      // Manual select
      en = 1'b1; mode = 1'b0; slt_line = 2'd2;
      step();
      chk_main("man_sel2", 8'h33, 1'b1, 2'd2, 1'b0);
      chk("ch3_sel2.out", 32'(out_b), 32'h33);
      slt_line = 2'd0;
      step();
      chk_main("man_sel0", 8'h11, 1'b1, 2'd0, 1'b0);

      // Out-of-range select on the 3-channel build holds out and cur_ch
      slt_line = 2'd3;
      step();
      chk("ch3_oor.out", 32'(out_b), 32'h11);
      chk("ch3_oor.vld", 32'(vld_b), 32'h0);
      chk("ch3_oor.cur", 32'(cur_b), 32'h0);
      chk_main("man_sel3", 8'h44, 1'b1, 2'd3, 1'b0);

      // Scan sequence; dwell-1 build enters scan on the same edge
      mode = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         chk_main($sformatf("scan%0d", i), scan_out[i], 1'b1, scan_cur[i], scan_wrap[i]);
         if (i < 8) begin
            chk($sformatf("dw1_%0d.out", i),  32'(out_c),  32'(dw1_out[i]));
            chk($sformatf("dw1_%0d.wrap", i), 32'(wrap_c), 32'(dw1_wrap[i]));
         end
      end

      // Pause during the second 0x22 cycle
      step();
      chk_main("p_22a", 8'h22, 1'b1, 2'd1, 1'b0);
      step();
      chk_main("p_22b", 8'h22, 1'b1, 2'd1, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_main($sformatf("paused%0d", i), 8'h22, 1'b0, 2'd1, 1'b0);
      end
      en = 1'b1;
      step();
      chk_main("resume_22", 8'h22, 1'b1, 2'd1, 1'b0);
      step();
      chk_main("resume_33", 8'h33, 1'b1, 2'd2, 1'b0);

      // Advance to channel 3, then switch to manual and back
      step();
      step();
      step();
      chk_main("to_ch3", 8'h44, 1'b1, 2'd3, 1'b0);
      mode = 1'b0; slt_line = 2'd1;
      step();
      chk_main("sw_man", 8'h22, 1'b1, 2'd1, 1'b0);
      mode = 1'b1;
      step();
      chk_main("sw_scan", 8'h11, 1'b1, 2'd0, 1'b0);

      // Live input change on the current channel is tracked
      in_bus[7:0] = 8'h5A;
      step();
      chk_main("live_trk", 8'h5A, 1'b1, 2'd0, 1'b0);
      in_bus[7:0] = 8'h11;

      // Reset mid-scan aborts immediately
      rst = 1'b1;
      step();
      chk_main("rst_mid", 8'h00, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;
      en  = 1'b0;
      step();
      chk_main("rst_idle", 8'h00, 1'b0, 2'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_nx1_scan.md
# mux_nx1_scan

Parametrised, registered N-to-1 multiplexer; successor to the registered 2:1 mux. It selects one of CHANNELS input words of WIDTH bits either from an external select (manual mode) or from an internal round-robin scanner that dwells DWELL cycles per channel (scan mode). Used wherever several sensor/data lanes share one downstream consumer. It provides a registered output with a valid flag, the current channel index and a wrap pulse.

## Interface

Parameters:
- WIDTH, 8, bits per channel word (>= 1)
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select/index width; must satisfy 2**SEL_W >= CHANNELS
- DWELL, 4, cycles each channel is presented in scan mode (>= 1)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_bus  input  CHANNELS*WIDTH  packed inputs; channel k = in_bus[k*WIDTH +: WIDTH]
- slt_line  input  SEL_W  manual channel select
- mode  input  1  0 = manual, 1 = scan
- en  input  1  enable; 0 = pause
- out  output  WIDTH  registered selected word
- out_valid  output  1  out holds a valid selected word this cycle
- cur_ch  output  SEL_W  channel index currently driven on out
- ch_wrap  output  1  one-cycle pulse when scan wraps to channel 0

## Operation

- States: IDLE (after reset only), MANUAL, SCAN. Transitions are evaluated only when en=1:
  - mode=0 -> MANUAL
  - mode=1 -> SCAN
- While en=0: state, cur_ch and dwell counter are frozen; out holds its value; out_valid=0; ch_wrap=0.
- MANUAL, en=1:
  - slt_line < CHANNELS: out <= channel[slt_line], cur_ch <= slt_line, out_valid <= 1.
  - slt_line >= CHANNELS: out and cur_ch hold, out_valid <= 0.
- Entering SCAN (from IDLE or MANUAL, en=1, mode=1): cur_ch <= 0, dwell <= 0, out <= channel[0], out_valid <= 1, ch_wrap <= 0.
- In SCAN, en=1, mode=1:
  - If dwell == DWELL-1: cur_ch advances to (cur_ch+1) mod CHANNELS, dwell <= 0, and out <= channel[next].
  - Otherwise dwell increments and out <= channel[cur_ch]. Live input changes on the current channel are tracked each cycle.
- ch_wrap <= 1 exactly on the advance from CHANNELS-1 to 0; it is 0 otherwise. It is not asserted on scan entry.
- Pause/resume in SCAN continues the same channel and dwell count; no restart.
- SCAN -> MANUAL -> SCAN restarts the scan at channel 0.
- Dwell counter width is clog2(DWELL)+1, and it never exceeds DWELL-1.
- DWELL=1 advances the channel every enabled cycle.

## Timing

- Reset (rst=1 at an edge, regardless of en/mode): out=0, out_valid=0, cur_ch=0, ch_wrap=0, dwell=0, state=IDLE, from the next cycle. Reset mid-scan aborts immediately.
- Latency is 1 cycle from sampled inputs (in_bus, slt_line, mode, en) to out/out_valid/cur_ch.
- In steady scan each channel appears on out for exactly DWELL consecutive enabled cycles. A full cycle is CHANNELS*DWELL enabled cycles.
- A mode change takes effect on the edge where it is sampled with en=1.
- rst has priority over en; en has priority over mode.
- No combinational path from inputs to outputs.

## Test plan

Configuration: WIDTH=8, CHANNELS=4, DWELL=3; channels 0..3 = 0x11, 0x22, 0x33, 0x44.

1. Reset: assert rst for 2 cycles with en=1, mode=1 -> out=0x00, out_valid=0, cur_ch=0, ch_wrap=0; remains IDLE with en=0 after release.
2. Manual select: mode=0, en=1, slt_line=2 -> next cycle out=0x33, cur_ch=2, out_valid=1. Then slt_line=0 -> out=0x11 one cycle later.
3. Scan sequence: mode=1, en=1 for 15 cycles -> out shows 0x11 x3, 0x22 x3, 0x33 x3, 0x44 x3, then 0x11. ch_wrap=1 only on the cycle the second 0x11 first appears.
4. Pause: in scan, drop en for 4 cycles during the second 0x22 cycle -> out holds 0x22 with out_valid=0. After resume, 0x22 is shown 1 more cycle, then 0x33.
5. Mode switch: mid-scan on channel 3, set mode=0 with slt_line=1 -> out=0x22. Return to mode=1 -> out=0x11, cur_ch=0, no ch_wrap.
6. Edge cases:
   - CHANNELS=3 build, manual slt_line=3 -> out holds previous value, out_valid=0.
   - DWELL=1 build -> scan changes channel every cycle.
